// File: rtl/jump_pkg.sv
//------------------------------------------------------------------------------
// Module : jump_pkg
// Brief  : Shared state encoding and datapath widths for the jump controller.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package jump_pkg;

  localparam int VY_W     = 12;
  localparam int H_ACC_W  = 24;
  localparam int DIST_W   = 11;
  localparam int HEIGHT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_FLY  = 2'd2,
    ST_DONE = 2'd3
  } jump_state_t;

endpackage

`default_nettype wire

// File: rtl/jump_tick_gen.sv
//------------------------------------------------------------------------------
// Module : jump_tick_gen
// Brief  : One-cycle frame tick on each rising edge of vsync.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module jump_tick_gen (
  input  logic clk_machine,
  input  logic rst_machine,
  input  logic i_vsync,
  output logic o_tick
);

  logic r_vsync_q;

  always_ff @(posedge clk_machine) begin
    if (rst_machine) begin
      r_vsync_q <= 1'b0;
    end else begin
      r_vsync_q <= i_vsync;
    end
  end

  assign o_tick = i_vsync & ~r_vsync_q;

endmodule

`default_nettype wire

// File: rtl/jump_trajectory_ctrl.sv
//------------------------------------------------------------------------------
// Module : jump_trajectory_ctrl
// Brief  : Steps one ballistic jump per frame tick; done/ack handshake on land.
//          Optional JUMP_AIRTIME_EN adds the o_air_ticks frame counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module jump_trajectory_ctrl
  import jump_pkg::*;
#(
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned DIST_STEP  = 3,
  parameter int unsigned DIST_MAX   = 2047,
  parameter int unsigned HEIGHT_MAX = 511
) (
  input  logic                clk_machine,
  input  logic                rst_machine,
  input  logic                i_jump_en,
  input  logic [VY_W-2:0]     i_jump_v_init,
  input  logic                i_vsync,
  output logic [DIST_W-1:0]   o_jump_dist,
  output logic [HEIGHT_W-1:0] o_jump_height,
  output logic                o_jump_done,
  output logic                o_busy
`ifdef JUMP_AIRTIME_EN
  ,
  output logic [7:0]          o_air_ticks
`endif
);

  localparam logic [VY_W:0]    c_gravity  = (VY_W+1)'(GRAVITY);
  localparam logic [DIST_W:0]  c_step     = (DIST_W+1)'(DIST_STEP);
  localparam logic [DIST_W:0]  c_dist_max = (DIST_W+1)'(DIST_MAX);
  localparam logic [H_ACC_W-1:0] c_h_max  = H_ACC_W'(HEIGHT_MAX);

  jump_state_t r_state;
  jump_state_t w_state_n;

  logic                      w_tick;
  logic                      w_step;
  logic                      w_land;
  logic [VY_W-1:0]           r_vy;
  logic [H_ACC_W-1:0]        r_h;
  logic [DIST_W-1:0]         r_dist;
  logic [HEIGHT_W-1:0]       r_height;
  logic                      r_done;
  logic                      r_busy;
  logic                      w_done_n;
  logic                      w_busy_n;

  logic [H_ACC_W-1:0]        w_h_n;
  logic                      w_h_le0;
  logic                      w_vy_le0;
  logic [VY_W:0]             w_vy_dec;
  logic [VY_W-1:0]           w_vy_n;
  logic [DIST_W:0]           w_dist_sum;
  logic [DIST_W-1:0]         w_dist_n;
  logic [HEIGHT_W-1:0]       w_height_n;

  jump_tick_gen u_tick_gen (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .i_vsync     (i_vsync),
    .o_tick      (w_tick)
  );

  // Trajectory arithmetic; sign tests use the MSB so every compare stays unsigned.
  always_comb begin
    w_h_n      = r_h + {{(H_ACC_W-VY_W){r_vy[VY_W-1]}}, r_vy};
    w_h_le0    = w_h_n[H_ACC_W-1] | (w_h_n == '0);
    w_vy_le0   = r_vy[VY_W-1] | (r_vy == '0);
    w_land     = w_vy_le0 & w_h_le0;
    w_vy_dec   = {r_vy[VY_W-1], r_vy} - c_gravity;
    w_vy_n     = (w_vy_dec[VY_W] != w_vy_dec[VY_W-1]) ? {1'b1, {(VY_W-1){1'b0}}}
                                                       : w_vy_dec[VY_W-1:0];
    w_dist_sum = {1'b0, r_dist} + c_step;
    w_dist_n   = (w_dist_sum > c_dist_max) ? c_dist_max[DIST_W-1:0]
                                            : w_dist_sum[DIST_W-1:0];
    if (w_h_n[H_ACC_W-1]) begin
      w_height_n = '0;
    end else if (w_h_n > c_h_max) begin
      w_height_n = c_h_max[HEIGHT_W-1:0];
    end else begin
      w_height_n = w_h_n[HEIGHT_W-1:0];
    end
  end

  always_ff @(posedge clk_machine) begin
    if (rst_machine) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Dropping i_jump_en wins over any same-cycle tick or landing.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: if (i_jump_en) w_state_n = ST_ARM;
      ST_ARM:  w_state_n = i_jump_en ? ST_FLY : ST_IDLE;
      ST_FLY: begin
        if (!i_jump_en) begin
          w_state_n = ST_IDLE;
        end else if (w_tick && w_land) begin
          w_state_n = ST_DONE;
        end
      end
      ST_DONE: if (!i_jump_en) w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy_n = (w_state_n != ST_IDLE);
    w_done_n = (w_state_n == ST_DONE);
  end

  assign w_step = (r_state == ST_FLY) && (w_state_n != ST_IDLE) && w_tick;

  always_ff @(posedge clk_machine) begin
    if (rst_machine) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_n;
      r_done <= w_done_n;
    end
  end

  always_ff @(posedge clk_machine) begin
    if (rst_machine || (w_state_n == ST_IDLE)) begin
      r_vy     <= '0;
      r_h      <= '0;
      r_dist   <= '0;
      r_height <= '0;
    end else if (r_state == ST_ARM) begin
      r_vy     <= {1'b0, i_jump_v_init};
      r_h      <= '0;
      r_dist   <= '0;
      r_height <= '0;
    end else if (w_step) begin
      r_vy   <= w_vy_n;
      r_dist <= w_dist_n;
      if (w_land) begin
        r_h      <= '0;
        r_height <= '0;
      end else begin
        r_h      <= w_h_n;
        r_height <= w_height_n;
      end
    end
  end

`ifdef JUMP_AIRTIME_EN
  logic [7:0] r_air_ticks;

  always_ff @(posedge clk_machine) begin
    if (rst_machine || (w_state_n == ST_IDLE) || (r_state == ST_ARM)) begin
      r_air_ticks <= '0;
    end else if (w_step && (r_air_ticks != 8'hFF)) begin
      r_air_ticks <= r_air_ticks + 8'd1;
    end
  end

  assign o_air_ticks = r_air_ticks;
`endif

  assign o_jump_dist   = r_dist;
  assign o_jump_height = r_height;
  assign o_jump_done   = r_done;
  assign o_busy        = r_busy;

endmodule

`default_nettype wire
